// File: rtl/video_stream_transmitter.sv
// Raster stream transmitter: pulls pixels over valid/ready and emits
// frame-valid / line-valid / data with parameterised blanking.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          frame request, honoured only while idle
//   i_data_valid     upstream pixel available
//   i_data           upstream pixel
//   o_data_ready     pixel consumed on this edge (combinational, state==ACTIVE)
//   o_v_aync         frame valid (registered)
//   o_h_aync         line valid, o_data meaningful when high (registered)
//   o_data           output pixel, zero outside active pixels
//   o_busy           high from start acceptance until the frame ends
//   o_underflow      pulse on an active pixel that had no valid input
//   o_frame_done     pulse on the first o_v_aync-low cycle after a frame
module video_stream_transmitter #(
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_IMAGE_WIDTH  = 256,
    parameter int P_IMAGE_HEIGHT = 256,
    parameter int P_H_BLANK      = 16,
    parameter int P_V_FRONT      = 4,
    parameter int P_V_BACK       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_data_valid,
    input  logic [P_DATA_WIDTH-1:0] i_data,
    output logic                    o_data_ready,
    output logic                    o_v_aync,
    output logic                    o_h_aync,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_underflow,
    output logic                    o_frame_done
);

    localparam logic [15:0] LP_W_LAST = 16'(P_IMAGE_WIDTH - 1);
    localparam logic [15:0] LP_H_LAST = 16'(P_IMAGE_HEIGHT - 1);
    localparam logic [15:0] LP_B_LAST = 16'(P_H_BLANK - 1);
    localparam logic [15:0] LP_F_LAST = 16'(P_V_FRONT - 1);
    localparam logic [15:0] LP_K_LAST = 16'(P_V_BACK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_FRONT,
        S_ACTIVE,
        S_H_BLANK,
        S_V_BACK
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pix_cnt, pix_nxt;
    logic [15:0] line_cnt, line_nxt;
    logic [15:0] blank_cnt, blank_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_nxt;
            line_cnt  <= line_nxt;
            blank_cnt <= blank_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        line_nxt  = line_cnt;
        blank_nxt = blank_cnt;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_V_FRONT;
                    blank_nxt = '0;
                end
            end
            S_V_FRONT: begin
                if (blank_cnt == LP_F_LAST) begin
                    state_nxt = S_ACTIVE;
                    blank_nxt = '0;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (pix_cnt == LP_W_LAST) begin
                    pix_nxt = '0;
                    if (line_cnt == LP_H_LAST) begin
                        line_nxt  = '0;
                        state_nxt = S_V_BACK;
                    end else begin
                        line_nxt  = line_cnt + 16'd1;
                        state_nxt = S_H_BLANK;
                    end
                end else begin
                    pix_nxt = pix_cnt + 16'd1;
                end
            end
            S_H_BLANK: begin
                if (blank_cnt == LP_B_LAST) begin
                    state_nxt = S_ACTIVE;
                    blank_nxt = '0;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            S_V_BACK: begin
                if (blank_cnt == LP_K_LAST) begin
                    state_nxt = S_IDLE;
                    blank_nxt = '0;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_data_ready = (state == S_ACTIVE);

    // Outputs trail the state by one cycle. frame_done fires when the
    // registered frame-valid is still high but the state is back in IDLE,
    // i.e. one cycle after the last V_BACK output cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_v_aync     <= 1'b0;
            o_h_aync     <= 1'b0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_underflow  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_v_aync     <= (state != S_IDLE);
            o_h_aync     <= (state == S_ACTIVE);
            o_data       <= (o_data_ready && i_data_valid) ? i_data : '0;
            o_busy       <= (state != S_IDLE);
            o_underflow  <= o_data_ready && !i_data_valid;
            o_frame_done <= (state == S_IDLE) && o_v_aync;
        end
    end

endmodule

// File: tb/tb_video_stream_transmitter.sv
// Directed bench for video_stream_transmitter: small 4x2 geometry tables
// plus one full-size default-geometry frame.
module tb_video_stream_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dv = 1'b1;
    logic [7:0] din = 8'd1;
    logic       rdy, v, h, busy, uf, done;
    logic [7:0] dout;

    logic       b_start = 1'b0;
    logic       b_dv = 1'b1;
    logic [7:0] b_din = 8'h5a;
    logic       b_rdy, b_v, b_h, b_busy, b_uf, b_done;
    logic [7:0] b_dout;

    always #5 clk = ~clk;

    video_stream_transmitter #(
        .P_DATA_WIDTH(8), .P_IMAGE_WIDTH(4), .P_IMAGE_HEIGHT(2),
        .P_H_BLANK(2), .P_V_FRONT(1), .P_V_BACK(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_data_valid(dv), .i_data(din),
        .o_data_ready(rdy), .o_v_aync(v), .o_h_aync(h),
        .o_data(dout), .o_busy(busy), .o_underflow(uf),
        .o_frame_done(done)
    );

    video_stream_transmitter dut_big (
        .i_clk(clk), .i_rst(rst), .i_start(b_start),
        .i_data_valid(b_dv), .i_data(b_din),
        .o_data_ready(b_rdy), .o_v_aync(b_v), .o_h_aync(b_h),
        .o_data(b_dout), .o_busy(b_busy), .o_underflow(b_uf),
        .o_frame_done(b_done)
    );

    typedef struct {
        logic       st;
        logic       ev;
        logic       eh;
        logic [7:0] ed;
        logic [7:0] edu;
        logic       euf;
        logic       edn;
        logic       erd;
    } vec_t;

    vec_t tbl [0:13];

    int n_cmp = 0;
    int n_err = 0;

    int e;
    int next_pix;
    int acc;
    int drop_at;
    int pops;
    logic       s_v   [0:63];
    logic       s_h   [0:63];
    logic [7:0] s_d   [0:63];
    logic       s_uf  [0:63];
    logic       s_dn  [0:63];
    logic       s_bs  [0:63];
    logic       s_rd  [0:63];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
        s_v[e]  = v;
        s_h[e]  = h;
        s_d[e]  = dout;
        s_uf[e] = uf;
        s_dn[e] = done;
        s_bs[e] = busy;
        s_rd[e] = rdy;
        din = 8'(next_pix);
        if (rdy) begin
            dv = (acc != drop_at);
            if (dv) begin
                next_pix++;
                pops++;
            end
            acc++;
        end else begin
            dv = 1'b1;
        end
    endtask

    task automatic frame_init(input int drop);
        e        = -1;
        next_pix = 1;
        acc      = 0;
        pops     = 0;
        drop_at  = drop;
        dv       = 1'b1;
        din      = 8'd1;
    endtask

    task automatic run(input int drop, input int pulse_at, input bit hold);
        frame_init(drop);
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st || (i == pulse_at) || hold;
            step();
        end
        start = hold;
    endtask

    task automatic compare(input string tag, input bit use_uf);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("%s v[%0d]", tag, i), int'(s_v[i]), int'(tbl[i].ev));
            chk($sformatf("%s h[%0d]", tag, i), int'(s_h[i]), int'(tbl[i].eh));
            chk($sformatf("%s d[%0d]", tag, i), int'(s_d[i]),
                use_uf ? int'(tbl[i].edu) : int'(tbl[i].ed));
            chk($sformatf("%s uf[%0d]", tag, i), int'(s_uf[i]),
                use_uf ? int'(tbl[i].euf) : 0);
            chk($sformatf("%s done[%0d]", tag, i), int'(s_dn[i]), int'(tbl[i].edn));
            chk($sformatf("%s busy[%0d]", tag, i), int'(s_bs[i]), int'(tbl[i].ev));
            chk($sformatf("%s rdy[%0d]", tag, i), int'(s_rd[i]), int'(tbl[i].erd));
        end
    endtask

    int  vcnt, hcnt, ucnt, cyc;
    bit  seen;

    initial begin
        //        st  v  h  d   du  uf dn rd
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 1, 1, 1, 1, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 2, 2, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 3, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 1, 4, 3, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 1, 1, 5, 4, 0, 0, 1};
        tbl[9]  = '{0, 1, 1, 6, 5, 0, 0, 1};
        tbl[10] = '{0, 1, 1, 7, 6, 0, 0, 1};
        tbl[11] = '{0, 1, 1, 8, 7, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset v", int'(v), 0);
        chk("reset h", int'(h), 0);
        chk("reset rdy", int'(rdy), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset data", int'(dout), 0);
        chk("reset done", int'(done), 0);
        chk("reset big v", int'(b_v), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(-1, -1, 1'b0);
        compare("basic", 1'b0);
        chk("basic pops", pops, 8);
        for (int i = 1; i < 13; i++)
            if (s_rd[i])
                chk($sformatf("align h after rdy[%0d]", i), int'(s_h[i+1]), 1);

        run(2, -1, 1'b0);
        compare("underflow", 1'b1);
        chk("underflow pops", pops, 7);

        run(-1, 4, 1'b0);
        compare("ignore", 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("ignore idle v[%0d]", e), int'(v), 0);
        end

        run(-1, -1, 1'b1);
        compare("hold", 1'b0);
        step();
        start = 1'b0;
        chk("hold next vfront v", int'(s_v[14]), 1);
        chk("hold next vfront h", int'(s_h[14]), 0);
        for (int i = 0; i < 12; i++) step();
        chk("hold next h[15]", int'(s_h[15]), 1);
        chk("hold next d[15]", int'(s_d[15]), 9);
        chk("hold next v[25]", int'(s_v[25]), 1);
        chk("hold next v[26]", int'(s_v[26]), 0);
        chk("hold next done[26]", int'(s_dn[26]), 1);
        step();

        frame_init(-1);
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st;
            step();
        end
        chk("pre-reset h", int'(h), 1);
        chk("pre-reset d", int'(dout), 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst v", int'(v), 0);
        chk("rst h", int'(h), 0);
        chk("rst d", int'(dout), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst uf", int'(uf), 0);
        chk("rst done", int'(done), 0);
        chk("rst rdy", int'(rdy), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("post-rst done[%0d]", i), int'(done), 0);
            chk($sformatf("post-rst v[%0d]", i), int'(v), 0);
        end
        run(-1, -1, 1'b0);
        compare("after-rst", 1'b0);

        vcnt = 0;
        hcnt = 0;
        ucnt = 0;
        seen = 1'b0;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (cyc = 0; cyc < 80000 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (b_v) vcnt++;
            if (b_h) hcnt++;
            if (b_uf) ucnt++;
            if (b_done) seen = 1'b1;
        end
        chk("big done seen", int'(seen), 1);
        chk("big v cycles", vcnt, 69624);
        chk("big h cycles", hcnt, 65536);
        chk("big underflow", ucnt, 0);
        chk("big pix_cnt", int'(dut_big.pix_cnt), 0);
        chk("big line_cnt", int'(dut_big.line_cnt), 0);
        chk("big blank_cnt", int'(dut_big.blank_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_stream_transmitter.md
Name: video_stream_transmitter

Overview:
Frame-timing transmitter. Pulls pixels from an upstream buffer over a valid/ready handshake and emits a raster stream with frame-valid (o_v_aync), line-valid (o_h_aync) and pixel data, the same sync format the alignment and filter stages consume. It sits at the output of a processing chain, or drives a stream into it from frame memory. Geometry and blanking are compile-time parameters.

Parameters:
P_DATA_WIDTH, 8, pixel width in bits
P_IMAGE_WIDTH, 256, active pixels per line (>=1)
P_IMAGE_HEIGHT, 256, active lines per frame (>=1)
P_H_BLANK, 16, h_aync-low cycles between consecutive lines (>=1)
P_V_FRONT, 4, v_aync-high, h_aync-low cycles before the first line (>=1)
P_V_BACK, 4, v_aync-high, h_aync-low cycles after the last line (>=1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset
i_start  input  1  frame request, sampled only in IDLE
i_data_valid  input  1  upstream pixel available
i_data  input  P_DATA_WIDTH  upstream pixel
o_data_ready  output  1  pixel consumed on this edge (combinational from state)
o_v_aync  output  1  frame valid
o_h_aync  output  1  line valid; o_data meaningful when high
o_data  output  P_DATA_WIDTH  output pixel
o_busy  output  1  high from start acceptance until the frame ends
o_underflow  output  1  one-cycle pulse, aligned with an active pixel that had no valid input
o_frame_done  output  1  one-cycle pulse on the first cycle o_v_aync is low after a frame

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high. On reset: state IDLE, all counters 0, and all outputs 0 on the next edge. Reset mid-frame aborts the frame with no o_frame_done. The upstream FIFO is not flushed.
- FSM states: IDLE, V_FRONT, ACTIVE, H_BLANK, V_BACK. Counters are 16-bit: pixel, line, blank.
  - IDLE: if i_start=1 -> V_FRONT.
  - V_FRONT: after P_V_FRONT cycles -> ACTIVE.
  - ACTIVE: after P_IMAGE_WIDTH cycles -> H_BLANK if lines remain, else V_BACK.
  - H_BLANK: after P_H_BLANK cycles -> ACTIVE.
  - V_BACK: after P_V_BACK cycles -> IDLE.
- All outputs except o_data_ready are registered, one cycle behind the state. If i_start is sampled at edge T0, o_v_aync rises in cycle T0+1.
- Frame shape, in cycles with o_v_aync=1 and in order:
  - P_V_FRONT cycles with h=0.
  - Per line: P_IMAGE_WIDTH cycles with h=1. Lines are separated by P_H_BLANK cycles with h=0, with no blank after the last line.
  - P_V_BACK cycles with h=0.
  - Total o_v_aync-high length = F + H*W + (H-1)*B + K.
- o_data_ready = (state==ACTIVE). It is high exactly in the cycle before each o_h_aync-high cycle.
- A pixel is taken on an edge where o_data_ready=1. If i_data_valid=1, o_data = i_data in the next cycle.
- If i_data_valid=0 at that edge, the timing is kept: o_h_aync is still 1, o_data = 0, and o_underflow pulses in the same cycle. No stall, no retry.
- o_data = 0 whenever o_h_aync = 0.
- o_frame_done: high for one cycle, in the cycle after the last V_BACK output cycle. In that cycle o_v_aync = 0.
- o_busy: high from T0+1 through the last o_v_aync-high cycle.
- i_start is ignored outside IDLE; it does not queue.
- Back-to-back frames: with i_start held high, the FSM spends exactly one cycle in IDLE. This gives a 1-cycle o_v_aync-low gap, which is also the o_frame_done cycle.
- The line counter wraps to 0 at end of frame. The pixel counter wraps to 0 at end of each line. Parameters must fit in 16 bits.

Test Plan:
- Basic frame: W=4, H=2, B=2, F=1, K=1, i_data_valid always 1, data 1..8. Expected:
  - o_v_aync high for 12 cycles from T0+1.
  - o_h_aync pattern 0,1,1,1,1,0,0,1,1,1,1,0.
  - o_data 1,2,3,4 then 5,6,7,8.
  - o_frame_done pulses at T0+13.
  - o_underflow never fires.
- Handshake alignment: same parameters. Expected: o_data_ready is high exactly 8 cycles, each one cycle ahead of an o_h_aync-high cycle. Upstream pops exactly 8 pixels.
- Underflow: drop i_data_valid on the 3rd accept. Expected:
  - Third output pixel is 0.
  - o_underflow pulses in that cycle.
  - Frame length is still 12. Remaining pixels 3..7 follow in order.
- Start handling: pulse i_start during ACTIVE. Expected: ignored, only one frame. Hold i_start high across the frame end. Expected: o_v_aync low for exactly 1 cycle (with o_frame_done=1), then the next frame's V_FRONT.
- Reset mid-frame: assert i_rst on line 2, pixel 2. Expected:
  - All outputs 0 on the next edge.
  - No o_frame_done.
  - A new i_start yields a complete, correctly shaped 12-cycle frame.
- Default geometry (256x256, B=16, F=4, K=4), one frame. Expected: o_v_aync high for 4+65536+4080+4 = 69624 cycles, 65536 h-high cycles, and the counters end at 0.
